// File: rtl/seq_gen_if.sv
// Control and serial-output bundle for seq_gen: start request with its pattern fields,
// and the registered serial stream with its status flags.
interface seq_gen_if #(
    parameter int PAT_W = 8,
    parameter int RPT_W = 4
) ();
    localparam int PLEN_W = $clog2(PAT_W + 1);

    logic              start;
    logic [PAT_W-1:0]  pattern;
    logic [PLEN_W-1:0] plen;
    logic [RPT_W-1:0]  rpt;
    logic              dout;
    logic              dvalid;
    logic              busy;
    logic              done;

    modport master (
        output start, pattern, plen, rpt,
        input  dout, dvalid, busy, done
    );

    modport slave (
        input  start, pattern, plen, rpt,
        output dout, dvalid, busy, done
    );
endinterface

// File: rtl/seq_gen.sv
// Serial pattern generator: sends pattern[plen-1:0] MSB-first rpt times, then pulses done.
// Define SEQ_GEN_GAP_EN to insert one idle GAP cycle between consecutive repetitions.
module seq_gen #(
    parameter int PAT_W = 8,
    parameter int RPT_W = 4
) (
    input  logic     clk,
    input  logic     reset,
    seq_gen_if.slave bus
);
    localparam int                PLEN_W   = $clog2(PAT_W + 1);
    localparam logic [PLEN_W-1:0] PLEN_MAX = PLEN_W'(PAT_W);
    localparam logic [PLEN_W-1:0] PLEN_ONE = PLEN_W'(1);
    localparam logic [RPT_W-1:0]  RPT_ONE  = RPT_W'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PAT_W-1:0]  r_pat;
    logic [PLEN_W-1:0] r_plen;
    logic [PLEN_W-1:0] r_idx;
    logic [PLEN_W-1:0] w_idx_nxt;
    logic [RPT_W-1:0]  r_rpt_left;
    logic [RPT_W-1:0]  w_rpt_nxt;
    logic              r_dout;
    logic              r_dvalid;
    logic              r_busy;
    logic              r_done;
    logic              w_dout_nxt;
    logic              w_dvalid_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_accept;
    logic [PLEN_W-1:0] w_plen_sat;
    logic [PLEN_W-1:0] w_first_idx;
    logic              w_start_bit;
    logic              w_restart_bit;
    logic              w_next_bit;

    assign w_plen_sat  = (bus.plen > PLEN_MAX) ? PLEN_MAX : bus.plen;
    assign w_first_idx = w_plen_sat - PLEN_ONE;

    // Bit selects done by shifting, so the index width need not match log2(PAT_W).
    assign w_start_bit   = 1'(bus.pattern >> w_first_idx);
    assign w_restart_bit = 1'(r_pat >> (r_plen - PLEN_ONE));
    assign w_next_bit    = 1'(r_pat >> (r_idx - PLEN_ONE));

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_rpt_nxt    = r_rpt_left;
        w_dout_nxt   = 1'b0;
        w_dvalid_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_accept     = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept  = 1'b1;
                    w_rpt_nxt = (bus.rpt == '0) ? '0 : bus.rpt - RPT_ONE;
                    if (w_plen_sat == '0) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt  = SHIFT;
                        w_idx_nxt    = w_first_idx;
                        w_dout_nxt   = w_start_bit;
                        w_dvalid_nxt = 1'b1;
                        w_busy_nxt   = 1'b1;
                    end
                end
            end

            SHIFT: begin
                if (r_idx != '0) begin
                    w_idx_nxt    = r_idx - PLEN_ONE;
                    w_dout_nxt   = w_next_bit;
                    w_dvalid_nxt = 1'b1;
                    w_busy_nxt   = 1'b1;
                end else if (r_rpt_left != '0) begin
                    w_rpt_nxt  = r_rpt_left - RPT_ONE;
                    w_busy_nxt = 1'b1;
`ifdef SEQ_GEN_GAP_EN
                    w_state_nxt = GAP;
`else
                    w_idx_nxt    = r_plen - PLEN_ONE;
                    w_dout_nxt   = w_restart_bit;
                    w_dvalid_nxt = 1'b1;
`endif
                end else begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                end
            end

            // Only reachable with the gap option; otherwise repetitions run back to back.
            GAP: begin
                w_state_nxt  = SHIFT;
                w_idx_nxt    = r_plen - PLEN_ONE;
                w_dout_nxt   = w_restart_bit;
                w_dvalid_nxt = 1'b1;
                w_busy_nxt   = 1'b1;
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_rpt_left <= '0;
            r_dout     <= 1'b0;
            r_dvalid   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_rpt_left <= w_rpt_nxt;
            r_dout     <= w_dout_nxt;
            r_dvalid   <= w_dvalid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Pattern and length are captured only when a start is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pat  <= '0;
            r_plen <= '0;
        end else if (w_accept) begin
            r_pat  <= bus.pattern;
            r_plen <= w_plen_sat;
        end
    end

    assign bus.dout   = r_dout;
    assign bus.dvalid = r_dvalid;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: a transfer-level model queues timed bit/done events,
// and a negedge monitor pops and compares them whenever the DUT shows dvalid or done.
module tb_seq_gen;
    localparam int PAT_W  = 8;
    localparam int RPT_W  = 4;
    localparam int PLEN_W = $clog2(PAT_W + 1);
`ifdef SEQ_GEN_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    seq_gen_if #(.PAT_W(PAT_W), .RPT_W(RPT_W)) bus ();

    seq_gen #(.PAT_W(PAT_W), .RPT_W(RPT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        bit val;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc       = 0;
    int  checks    = 0;
    int  errors    = 0;
    int  busy_lo   = 0;
    int  busy_hi   = -1;
    int  next_free = 0;

    // Cycle c is the interval after the c-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: start accepted at the coming edge n; bits, gaps and done laid out in time.
    task automatic push_transfer(input logic [PAT_W-1:0] p, input int l, input int r);
        int  n;
        int  pl;
        int  reps;
        int  d;
        ev_t ev;
        n    = cyc + 1;
        pl   = (l > PAT_W) ? PAT_W : l;
        reps = (r == 0) ? 1 : r;
        d    = (pl == 0) ? n : n + reps * pl + (reps - 1) * GAP;
        if (pl > 0) begin
            for (int k = 0; k < reps; k++) begin
                for (int i = 0; i < pl; i++) begin
                    ev.is_done = 1'b0;
                    ev.val     = p[pl-1-i];
                    ev.cyc     = n + k * (pl + GAP) + i;
                    exp_q.push_back(ev);
                end
            end
        end
        ev.is_done = 1'b1;
        ev.val     = 1'b0;
        ev.cyc     = d;
        exp_q.push_back(ev);
        busy_lo   = n;
        busy_hi   = d - 1;
        next_free = d + 2;
    endtask

    task automatic randomize_fields();
        bus.pattern = PAT_W'($urandom);
        bus.plen    = PLEN_W'($urandom);
        bus.rpt     = RPT_W'($urandom);
    endtask

    // Waits (with ignored start noise) until the model says the DUT is idle, then starts.
    task automatic start_xfer(input logic [PAT_W-1:0] p, input int l, input int r);
        @(negedge clk);
        while (cyc + 1 < next_free) begin
            bus.start = 1'($urandom_range(0, 1));
            randomize_fields();
            @(negedge clk);
        end
        bus.start   = 1'b1;
        bus.pattern = p;
        bus.plen    = PLEN_W'(l);
        bus.rpt     = RPT_W'(r);
        push_transfer(p, l, r);
        @(negedge clk);
        bus.start = 1'b0;
        randomize_fields();
    endtask

    always @(negedge clk) begin : monitor
        ev_t ev;
        if (bus.dvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dvalid: got dout=%0b with no expected bit (cycle %0d)", bus.dout, cyc);
            end else begin
                ev = exp_q.pop_front();
                check("bit_kind", 32'(ev.is_done), 32'(1'b0));
                check("bit_cycle", cyc, ev.cyc);
                check("dout", 32'(bus.dout), 32'(ev.val));
            end
        end else begin
            check("dout_zero_when_invalid", 32'(bus.dout), 32'(1'b0));
        end
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 with nothing expected (cycle %0d)", cyc);
            end else begin
                ev = exp_q.pop_front();
                check("done_kind", 32'(ev.is_done), 32'(1'b1));
                check("done_cycle", cyc, ev.cyc);
            end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_event: got nothing, expected %s at cycle %0d (now %0d)",
                     exp_q[0].is_done ? "done" : "bit", exp_q[0].cyc, cyc);
            ev = exp_q.pop_front();
        end
        check("busy", 32'(bus.busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start   = 1'b0;
        bus.pattern = '0;
        bus.plen    = '0;
        bus.rpt     = '0;
        #2;
        check("reset_dout", 32'(bus.dout), 32'(1'b0));
        check("reset_dvalid", 32'(bus.dvalid), 32'(1'b0));
        check("reset_busy", 32'(bus.busy), 32'(1'b0));
        check("reset_done", 32'(bus.done), 32'(1'b0));
        repeat (2) @(negedge clk);
        reset = 1'b0;

        start_xfer(8'h07, 3, 2);   // six ones (or 3+gap+3), then done
        start_xfer(8'hA5, 8, 1);   // 1,0,1,0,0,1,0,1
        start_xfer(8'h5A, 0, 3);   // no bits, done right after the start edge
        start_xfer(8'h02, 2, 0);   // rpt=0 sends 1,0 once
        start_xfer(8'hC3, 15, 2);  // plen saturates to PAT_W

        // Reset while the third bit is on dout: everything drops, no done follows.
        start_xfer(8'hA5, 8, 1);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        busy_lo   = 0;
        busy_hi   = -1;
        next_free = 0;
        #1;
        check("abort_dout", 32'(bus.dout), 32'(1'b0));
        check("abort_dvalid", 32'(bus.dvalid), 32'(1'b0));
        check("abort_busy", 32'(bus.busy), 32'(1'b0));
        check("abort_done", 32'(bus.done), 32'(1'b0));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        start_xfer(8'hA5, 8, 1);

        // Start held high through a transfer: next one is taken only after DONE.
        @(negedge clk);
        while (cyc + 1 < next_free) @(negedge clk);
        bus.start   = 1'b1;
        bus.pattern = 8'h96;
        bus.plen    = PLEN_W'(5);
        bus.rpt     = RPT_W'(2);
        push_transfer(8'h96, 5, 2);
        @(negedge clk);
        while (cyc + 1 < next_free) begin
            randomize_fields();
            @(negedge clk);
        end
        bus.pattern = 8'h3C;
        bus.plen    = PLEN_W'(6);
        bus.rpt     = RPT_W'(1);
        push_transfer(8'h3C, 6, 1);
        @(negedge clk);
        bus.start = 1'b0;

        for (int t = 0; t < 150; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            start_xfer(PAT_W'($urandom), $urandom_range(0, (1 << PLEN_W) - 1),
                       $urandom_range(0, (1 << RPT_W) - 1));
        end

        while (cyc < next_free) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
